fetch_mem_arbiter: RTL and testbench

- Shares one single-port SRAM between the instruction-fetch path and the MEM-stage data path.
- Serializes accesses with a fixed wait-state counter and returns registered read data to each side.
- Generates the freeze signals that hold the IF stage register and the rest of the pipeline while an access is outstanding.
- Sits between the PC/IF stage, the MEM stage and the external SRAM model.

---
 rtl/fetch_mem_arbiter_pkg.sv | 25 ++
 rtl/sram_wait_counter.sv | 36 +++
 rtl/fetch_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data SRAM arbiter and its wait-state counter.
package fetch_mem_arbiter_pkg;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WAIT_MIN = 1;
    localparam int unsigned WAIT_MAX = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_ACC,
        ST_IF_ACC,
        ST_MEM_RESP,
        ST_IF_RESP
    } arb_state_e;

    // Counter preload for a given wait-state count, clamped to the legal range.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned wait_cycles);
        int unsigned w;
        w = wait_cycles;
        if (w < WAIT_MIN) w = WAIT_MIN;
        if (w > WAIT_MAX) w = WAIT_MAX;
        return CNT_W'(w - 1);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter: load a preload value, decrement to zero, flag completion.
module sram_wait_counter
    import fetch_mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load wins over decrement; the count saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c = (count_q == '0);

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and the MEM stage,
// inserting fixed wait states and producing the IF/pipeline freeze signals.
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              freeze_if,
    output logic              freeze_pipe
);

    localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

    arb_state_e        state_q, state_d;
    logic              abort_q, abort_d;
    logic              sram_req_q, sram_req_d;
    logic              sram_we_q, sram_we_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_ready_q, mem_ready_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_done;
    logic mem_any;
    logic mem_pend;

    sram_wait_counter u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec),
        .done_c   (cnt_done)
    );

    assign mem_any = mem_rd_en | mem_wr_en;

    // Next-state and registered-output logic; data side always wins in IDLE.
    always_comb begin
        state_d      = state_q;
        abort_d      = abort_q;
        sram_req_d   = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_rdata_d   = if_rdata_q;
        if_valid_d   = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        mem_ready_d  = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_any) begin
                    state_d     = ST_MEM_ACC;
                    cnt_load    = 1'b1;
                    sram_req_d  = 1'b1;
                    sram_we_d   = mem_wr_en;
                    sram_addr_d = mem_addr;
                    if (mem_wr_en) begin
                        sram_wdata_d = mem_wdata;
                    end
                end else if (if_req) begin
                    state_d     = ST_IF_ACC;
                    cnt_load    = 1'b1;
                    sram_req_d  = 1'b1;
                    sram_addr_d = if_addr;
                end
            end
            ST_MEM_ACC: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    state_d     = ST_MEM_RESP;
                    mem_ready_d = 1'b1;
                    if (!sram_we_q) begin
                        mem_rdata_d = sram_rdata;
                    end
                end else begin
                    sram_req_d = 1'b1;
                    sram_we_d  = sram_we_q;
                end
            end
            ST_IF_ACC: begin
                cnt_dec = 1'b1;
                // A flush in the final access cycle still kills the response.
                abort_d = abort_q | flush;
                if (cnt_done) begin
                    state_d    = ST_IF_RESP;
                    if_valid_d = !abort_d;
                    if (!abort_d) begin
                        if_rdata_d = sram_rdata;
                    end
                end else begin
                    sram_req_d = 1'b1;
                end
            end
            ST_MEM_RESP, ST_IF_RESP: begin
                state_d = ST_IDLE;
                abort_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                abort_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            abort_q      <= 1'b0;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            mem_rdata_q  <= '0;
            mem_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_q      <= abort_d;
            sram_req_q   <= sram_req_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_rdata_q   <= if_rdata_d;
            if_valid_q   <= if_valid_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_ready_q  <= mem_ready_d;
        end
    end

    // Freezes follow the live requests; held low while reset is asserted.
    assign mem_pend    = !rst && mem_any && !mem_ready_q;
    assign freeze_pipe = mem_pend;
    assign freeze_if   = (!rst && if_req && !if_valid_q) || mem_pend;

    assign sram_req   = sram_req_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign if_valid   = if_valid_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_ready  = mem_ready_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed cycle table, randomized traffic against a
// transaction-level model, async reset mid-access, and a WAIT_CYCLES=1 instance.
`timescale 1ns/1ps
module tb_fetch_mem_arbiter;

    localparam int W = 3;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        mem_rd_en, mem_wr_en, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        sram_req, sram_we;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic        freeze_if, freeze_pipe;

    logic        w1_rst, w1_if_req, w1_if_valid, w1_mem_ready, w1_sram_req, w1_sram_we;
    logic        w1_freeze_if, w1_freeze_pipe;
    logic [31:0] w1_if_addr, w1_if_rdata, w1_mem_rdata, w1_sram_addr, w1_sram_wdata;

    fetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .freeze_if(freeze_if), .freeze_pipe(freeze_pipe)
    );

    fetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(w1_rst),
        .if_req(w1_if_req), .if_addr(w1_if_addr), .flush(1'b0),
        .if_rdata(w1_if_rdata), .if_valid(w1_if_valid),
        .mem_rd_en(1'b0), .mem_wr_en(1'b0), .mem_addr(32'h0),
        .mem_wdata(32'h0), .mem_rdata(w1_mem_rdata), .mem_ready(w1_mem_ready),
        .sram_req(w1_sram_req), .sram_we(w1_sram_we), .sram_addr(w1_sram_addr),
        .sram_wdata(w1_sram_wdata), .sram_rdata(32'hA5A5A5A5),
        .freeze_if(w1_freeze_if), .freeze_pipe(w1_freeze_pipe)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // One directed cycle: inputs driven, outputs expected in that same cycle.
    typedef struct {
        logic ir; logic [31:0] ia; logic fl; logic mr; logic mw;
        logic [31:0] ma; logic [31:0] mwd; logic [31:0] srd;
        logic e_req; logic e_we; logic [31:0] e_addr; logic [31:0] e_wd;
        logic e_iv; logic [31:0] e_ird; logic e_mr; logic [31:0] e_mrd;
        logic e_fi; logic e_fp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic fl, input logic mr, input logic mw,
        input logic [31:0] ma, input logic [31:0] mwd, input logic [31:0] srd,
        input logic e_req, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wd,
        input logic e_iv, input logic [31:0] e_ird, input logic e_mr, input logic [31:0] e_mrd,
        input logic e_fi, input logic e_fp);
        vec_t v;
        v.ir = ir; v.ia = ia; v.fl = fl; v.mr = mr; v.mw = mw; v.ma = ma; v.mwd = mwd; v.srd = srd;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_iv = e_iv; v.e_ird = e_ird; v.e_mr = e_mr; v.e_mrd = e_mrd;
        v.e_fi = e_fi; v.e_fp = e_fp;
        return v;
    endfunction

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0; flush = 1'b0;
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
        sram_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, ".sram_req"}, sram_req, 1'b0);
        chk1({tag, ".sram_we"}, sram_we, 1'b0);
        chk32({tag, ".sram_addr"}, sram_addr, 32'h0);
        chk32({tag, ".sram_wdata"}, sram_wdata, 32'h0);
        chk1({tag, ".if_valid"}, if_valid, 1'b0);
        chk32({tag, ".if_rdata"}, if_rdata, 32'h0);
        chk1({tag, ".mem_ready"}, mem_ready, 1'b0);
        chk32({tag, ".mem_rdata"}, mem_rdata, 32'h0);
        chk1({tag, ".freeze_if"}, freeze_if, 1'b0);
        chk1({tag, ".freeze_pipe"}, freeze_pipe, 1'b0);
    endtask

    // Transaction-level reference: one access occupies [start, start+W-1], responds at start+W.
    typedef enum int {K_IF, K_RD, K_WR} kind_e;
    int          cyc;
    bit          m_busy, m_abort;
    int          m_start;
    kind_e       m_kind;
    logic [31:0] m_addr, m_wdata, m_ird, m_mrd;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit   mem_act, if_act, last_iv, last_mr;
        bit   in_acc, in_resp, e_req, e_we, e_iv, e_mr, e_fp, e_fi;
        int   r, lat;

        rst = 1'b1; w1_rst = 1'b1; w1_if_req = 1'b0; w1_if_addr = '0;
        drive_idle();

        // Directed table: plain fetch, simultaneous requests, write, flushed fetch.
        vecs.push_back(mk(H,32'h40,L,L,L,Z,Z,32'hE3A01005, L,L,Z,Z,L,Z,L,Z,H,L));
        repeat (3) vecs.push_back(mk(H,32'h40,L,L,L,Z,Z,32'hE3A01005, H,L,32'h40,Z,L,Z,L,Z,H,L));
        vecs.push_back(mk(H,32'h40,L,L,L,Z,Z,32'hE3A01005, L,L,Z,Z,H,32'hE3A01005,L,Z,L,L));
        vecs.push_back(mk(L,32'h40,L,L,L,Z,Z,32'hE3A01005, L,L,Z,Z,L,32'hE3A01005,L,Z,L,L));

        vecs.push_back(mk(H,32'h44,L,H,L,32'h100,Z,32'h1234, L,L,Z,Z,L,32'hE3A01005,L,Z,H,H));
        repeat (3) vecs.push_back(mk(H,32'h44,L,H,L,32'h100,Z,32'h1234, H,L,32'h100,Z,L,32'hE3A01005,L,Z,H,H));
        vecs.push_back(mk(H,32'h44,L,H,L,32'h100,Z,32'h1234, L,L,Z,Z,L,32'hE3A01005,H,32'h1234,H,L));
        vecs.push_back(mk(H,32'h44,L,L,L,Z,Z,32'hE1A00000, L,L,Z,Z,L,32'hE3A01005,L,32'h1234,H,L));
        repeat (3) vecs.push_back(mk(H,32'h44,L,L,L,Z,Z,32'hE1A00000, H,L,32'h44,Z,L,32'hE3A01005,L,32'h1234,H,L));
        vecs.push_back(mk(H,32'h44,L,L,L,Z,Z,32'hE1A00000, L,L,Z,Z,H,32'hE1A00000,L,32'h1234,L,L));
        vecs.push_back(mk(L,32'h44,L,L,L,Z,Z,32'hE1A00000, L,L,Z,Z,L,32'hE1A00000,L,32'h1234,L,L));

        vecs.push_back(mk(L,Z,L,L,H,32'h200,32'hDEADBEEF,32'h55555555, L,L,Z,Z,L,32'hE1A00000,L,32'h1234,H,H));
        repeat (3) vecs.push_back(mk(L,Z,L,L,H,32'h200,32'hDEADBEEF,32'h55555555, H,H,32'h200,32'hDEADBEEF,L,32'hE1A00000,L,32'h1234,H,H));
        vecs.push_back(mk(L,Z,L,L,H,32'h200,32'hDEADBEEF,32'h55555555, L,L,Z,Z,L,32'hE1A00000,H,32'h1234,L,L));
        vecs.push_back(mk(L,Z,L,L,L,Z,Z,32'h55555555, L,L,Z,Z,L,32'hE1A00000,L,32'h1234,L,L));

        vecs.push_back(mk(H,32'h48,L,L,L,Z,Z,32'hFFFFFFFF, L,L,Z,Z,L,32'hE1A00000,L,32'h1234,H,L));
        vecs.push_back(mk(H,32'h48,L,L,L,Z,Z,32'hFFFFFFFF, H,L,32'h48,Z,L,32'hE1A00000,L,32'h1234,H,L));
        vecs.push_back(mk(H,32'h48,H,L,L,Z,Z,32'hFFFFFFFF, H,L,32'h48,Z,L,32'hE1A00000,L,32'h1234,H,L));
        vecs.push_back(mk(H,32'h48,L,L,L,Z,Z,32'hFFFFFFFF, H,L,32'h48,Z,L,32'hE1A00000,L,32'h1234,H,L));
        vecs.push_back(mk(H,32'h48,L,L,L,Z,Z,32'hFFFFFFFF, L,L,Z,Z,L,32'hE1A00000,L,32'h1234,H,L));
        vecs.push_back(mk(H,32'h60,L,L,L,Z,Z,32'h11111111, L,L,Z,Z,L,32'hE1A00000,L,32'h1234,H,L));
        repeat (3) vecs.push_back(mk(H,32'h60,L,L,L,Z,Z,32'h11111111, H,L,32'h60,Z,L,32'hE1A00000,L,32'h1234,H,L));
        vecs.push_back(mk(H,32'h60,L,L,L,Z,Z,32'h11111111, L,L,Z,Z,H,32'h11111111,L,32'h1234,L,L));
        vecs.push_back(mk(L,32'h60,L,L,L,Z,Z,32'h11111111, L,L,Z,Z,L,32'h11111111,L,32'h1234,L,L));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            if_req = vecs[i].ir; if_addr = vecs[i].ia; flush = vecs[i].fl;
            mem_rd_en = vecs[i].mr; mem_wr_en = vecs[i].mw;
            mem_addr = vecs[i].ma; mem_wdata = vecs[i].mwd; sram_rdata = vecs[i].srd;
            @(negedge clk);
            chk1($sformatf("v%0d.sram_req", i), sram_req, vecs[i].e_req);
            chk1($sformatf("v%0d.sram_we", i), sram_we, vecs[i].e_we);
            if (vecs[i].e_req) chk32($sformatf("v%0d.sram_addr", i), sram_addr, vecs[i].e_addr);
            if (vecs[i].e_we) chk32($sformatf("v%0d.sram_wdata", i), sram_wdata, vecs[i].e_wd);
            chk1($sformatf("v%0d.if_valid", i), if_valid, vecs[i].e_iv);
            chk32($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].e_ird);
            chk1($sformatf("v%0d.mem_ready", i), mem_ready, vecs[i].e_mr);
            chk32($sformatf("v%0d.mem_rdata", i), mem_rdata, vecs[i].e_mrd);
            chk1($sformatf("v%0d.freeze_if", i), freeze_if, vecs[i].e_fi);
            chk1($sformatf("v%0d.freeze_pipe", i), freeze_pipe, vecs[i].e_fp);
            @(posedge clk); #1;
        end

        // Randomized traffic from a clean reset.
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_busy = 0; m_abort = 0; m_start = 0; m_kind = K_IF;
        m_addr = '0; m_wdata = '0; m_ird = '0; m_mrd = '0;
        mem_act = 0; if_act = 0; last_iv = 0; last_mr = 0;
        cyc = 0;
        for (int n = 0; n < 600; n++) begin
            if (mem_act && last_mr) begin
                mem_act = 0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
            end
            if (!mem_act && $urandom_range(0, 3) == 0) begin
                mem_act = 1;
                r = int'($urandom_range(0, 4));
                mem_rd_en = (r != 3);
                mem_wr_en = (r >= 3);
                mem_addr  = {$urandom_range(0, 1023), 2'b00};
                mem_wdata = $urandom;
            end
            if (if_act && last_iv) begin
                if_act = 0; if_req = 1'b0;
            end
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1; if_req = 1'b1;
                if_addr = {$urandom_range(0, 1023), 2'b00};
            end
            flush = ($urandom_range(0, 5) == 0);
            if (flush && if_act) if_addr = {$urandom_range(0, 1023), 2'b00};
            sram_rdata = $urandom;

            @(negedge clk);
            in_acc  = m_busy && (cyc >= m_start) && (cyc < m_start + W);
            in_resp = m_busy && (cyc == m_start + W);
            e_req = in_acc;
            e_we  = in_acc && (m_kind == K_WR);
            e_iv  = in_resp && (m_kind == K_IF) && !m_abort;
            e_mr  = in_resp && (m_kind != K_IF);
            e_fp  = (mem_rd_en || mem_wr_en) && !e_mr;
            e_fi  = (if_req && !e_iv) || e_fp;
            chk1("r.sram_req", sram_req, e_req);
            chk1("r.sram_we", sram_we, e_we);
            if (e_req) chk32("r.sram_addr", sram_addr, m_addr);
            if (e_we) chk32("r.sram_wdata", sram_wdata, m_wdata);
            chk1("r.if_valid", if_valid, e_iv);
            chk1("r.mem_ready", mem_ready, e_mr);
            chk32("r.if_rdata", if_rdata, m_ird);
            chk32("r.mem_rdata", mem_rdata, m_mrd);
            chk1("r.freeze_if", freeze_if, e_fi);
            chk1("r.freeze_pipe", freeze_pipe, e_fp);

            if (in_acc && (m_kind == K_IF) && flush) m_abort = 1;
            if (m_busy && (cyc == m_start + W - 1)) begin
                if (m_kind == K_IF && !m_abort) m_ird = sram_rdata;
                if (m_kind == K_RD) m_mrd = sram_rdata;
            end
            if (!m_busy) begin
                if (mem_rd_en || mem_wr_en) begin
                    m_busy = 1; m_start = cyc + 1; m_abort = 0;
                    m_kind = mem_wr_en ? K_WR : K_RD;
                    m_addr = mem_addr;
                    if (mem_wr_en) m_wdata = mem_wdata;
                end else if (if_req) begin
                    m_busy = 1; m_start = cyc + 1; m_abort = 0;
                    m_kind = K_IF; m_addr = if_addr;
                end
            end else if (in_resp) begin
                m_busy = 0;
            end
            last_iv = e_iv; last_mr = e_mr;
            cyc++;
            @(posedge clk); #1;
        end

        // Drain, then reset in the second MEM_ACC cycle of a read.
        drive_idle();
        repeat (W + 4) @(posedge clk);
        #1;
        mem_rd_en = 1'b1; mem_addr = 32'h300; sram_rdata = 32'h0BAD0BAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("rm.sram_req_before", sram_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rm");
        mem_rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1($sformatf("rm.no_ready[%0d]", k), mem_ready, 1'b0);
            @(posedge clk); #1;
        end
        mem_rd_en = 1'b1; mem_addr = 32'h304; sram_rdata = 32'hCAFE0001;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_ready && lat < 0) lat = k;
            @(posedge clk); #1;
            if (lat >= 0) mem_rd_en = 1'b0;
        end
        chk32("rm.latency", 32'(lat), 32'(W + 1));
        chk32("rm.mem_rdata", mem_rdata, 32'hCAFE0001);

        // WAIT_CYCLES=1 instance: continuous fetch, valid every third cycle.
        w1_rst = 1'b0; w1_if_req = 1'b1; w1_if_addr = 32'h80;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk1($sformatf("w1.if_valid[%0d]", k), w1_if_valid, (k % 3 == 2));
            if (k == 2) chk32("w1.if_rdata", w1_if_rdata, 32'hA5A5A5A5);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
